// File: rtl/varredura_display_letras.sv
// Scanned driver for a bank of common-anode 7-segment letter digits (A-H).
// Inputs are sampled only at frame wrap so a frame never mixes old and new data.
module varredura_display_letras #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3*N_DIGITS-1:0]   codes,
  input  logic [N_DIGITS-1:0]     en,
  input  logic [N_DIGITS-1:0]     blink,
  output logic [6:0]              seg_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic [3*N_DIGITS-1:0] code_q, code_d;
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  done_q, done_d;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [2:0]            cur_code;
  logic                  cur_on;
  logic                  lit;

  function automatic logic [6:0] letter(input logic [2:0] c);
    logic [6:0] p;
    case (c)
      3'd0:    p = 7'h77;
      3'd1:    p = 7'h7C;
      3'd2:    p = 7'h39;
      3'd3:    p = 7'h5E;
      3'd4:    p = 7'h79;
      3'd5:    p = 7'h71;
      3'd6:    p = 7'h3D;
      default: p = 7'h76;
    endcase
    return p;
  endfunction

  always_comb begin
    slot_wrap  = (scan_q == SW'(SCAN_DIV - 1));
    frame_wrap = slot_wrap && (idx_q == IW'(N_DIGITS - 1));

    cur_code = '0;
    cur_on   = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code = code_q[3*i +: 3];
        cur_on   = en_q[i] && !(blink_q[i] && phase_q);
      end
    end

    scan_d = slot_wrap ? '0 : scan_q + SW'(1);
    idx_d  = idx_q;
    if (slot_wrap)
      idx_d = frame_wrap ? '0 : idx_q + IW'(1);

    frame_d = frame_q;
    phase_d = phase_q;
    code_d  = code_q;
    en_d    = en_q;
    blink_d = blink_q;
    if (frame_wrap) begin
      code_d  = codes;
      en_d    = en;
      blink_d = blink;
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    // slot 0 of every digit is dead time to stop ghosting
    lit   = (scan_q != '0) && cur_on;
    seg_d = lit ? ~letter(cur_code) : 7'h7F;
    an_d  = '1;
    for (int i = 0; i < N_DIGITS; i++)
      if (lit && idx_q == IW'(i))
        an_d[i] = 1'b0;

    done_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      code_q  <= '0;
      en_q    <= '0;
      blink_q <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      done_q  <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      code_q  <= code_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      done_q  <= done_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_varredura_display_letras.sv
// Scoreboard bench: driver pushes the expected display per cycle,
// a monitor on the falling edge pops and compares.
module tb_varredura_display_letras;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3*ND-1:0] codes;
  logic [ND-1:0]   en;
  logic [ND-1:0]   blink;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;
  logic            frame_done;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          fd;
  } exp_t;

  exp_t            q[$];
  int              total = 0;
  int              bad   = 0;
  int              k;
  logic [3*ND-1:0] m_codes;
  logic [ND-1:0]   m_en;
  logic [ND-1:0]   m_blink;

  always #5 clk = ~clk;

  varredura_display_letras #(
    .N_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .codes(codes), .en(en),
    .blink(blink), .seg_n(seg_n), .an_n(an_n),
    .frame_done(frame_done)
  );

  function automatic logic [6:0] pat(input logic [2:0] c);
    logic [6:0] p;
    case (c)
      3'd0:    p = 7'h77;
      3'd1:    p = 7'h7C;
      3'd2:    p = 7'h39;
      3'd3:    p = 7'h5E;
      3'd4:    p = 7'h79;
      3'd5:    p = 7'h71;
      3'd6:    p = 7'h3D;
      default: p = 7'h76;
    endcase
    return p;
  endfunction

  function automatic exp_t blank_e();
    exp_t e;
    e.an  = '1;
    e.seg = 7'h7F;
    e.fd  = 1'b0;
    return e;
  endfunction

  // Expected outputs right after edge kk (kk counted from reset release).
  function automatic exp_t model(input int kk);
    exp_t e;
    int   s, i, f;
    logic ph;
    e    = blank_e();
    e.fd = (kk >= FR) && (kk % FR == 0);
    s    = (kk - 1) % SD;
    i    = ((kk - 1) / SD) % ND;
    f    = (kk - 1) / FR;
    ph   = ((f / BF) % 2) == 1;
    if (s != 0 && m_en[i] && !(m_blink[i] && ph)) begin
      e.an[i] = 1'b0;
      e.seg   = ~pat(m_codes[3*i +: 3]);
    end
    return e;
  endfunction

  task automatic clear_model();
    k       = 0;
    m_codes = '0;
    m_en    = '0;
    m_blink = '0;
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    q.push_back(model(k));
    if (k % FR == 0) begin
      m_codes = codes;
      m_en    = en;
      m_blink = blink;
    end
  endtask

  task automatic run(input int n, input logic [3*ND-1:0] c,
                     input logic [ND-1:0] e, input logic [ND-1:0] b);
    #1;
    codes = c;
    en    = e;
    blink = b;
    repeat (n) step();
  endtask

  task automatic blank_cycle();
    @(posedge clk);
    q.push_back(blank_e());
  endtask

  task automatic mid_reset();
    exp_t e;
    int   tries;
    tries = 0;
    while (tries < 2 * FR && model(k + 1).an == '1) begin
      step();
      tries++;
    end
    @(posedge clk);
    k++;
    e = model(k);
    q.push_back(blank_e());
    #1;
    total++;
    if (an_n !== e.an || seg_n !== e.seg) begin
      bad++;
      $display("FAIL prereset_lit got an=%b seg=%h want an=%b seg=%h",
               an_n, seg_n, e.an, e.seg);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (an_n !== '1 || seg_n !== 7'h7F || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got an=%b seg=%h fd=%b want an=1111 seg=7f fd=0",
               an_n, seg_n, frame_done);
    end
    repeat (2) blank_cycle();
    #3 reset_n = 1'b1;
    clear_model();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (an_n !== e.an || seg_n !== e.seg || frame_done !== e.fd) begin
          bad++;
          $display("FAIL out k=%0d got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                   k, an_n, seg_n, frame_done, e.an, e.seg, e.fd);
        end
        total++;
        if (!$onehot0(~an_n)) begin
          bad++;
          $display("FAIL anode_onehot k=%0d got an=%b want at most one low",
                   k, an_n);
        end
      end
    end
  end

  initial begin : driver
    int waited;
    reset_n = 1'b0;
    codes   = '0;
    en      = '0;
    blink   = '0;
    clear_model();
    repeat (3) blank_cycle();
    #3 reset_n = 1'b1;

    run(40, 12'o7654, 4'hF, 4'h0);
    run(24, 12'o0000, 4'hF, 4'h0);
    run(32, 12'o0000, 4'b1011, 4'h0);
    run(96, 12'o3210, 4'hF, 4'b0001);
    run(20, 12'o7777, 4'hF, 4'h0);
    mid_reset();
    run(48, 12'o5123, 4'hF, 4'h0);
    for (int i = 0; i < 1000; i++)
      run(1, 12'($urandom), 4'($urandom), 4'($urandom));

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
